// File: rtl/idt_cfg_pkg.sv
// Shared field layout, FSM state codes and default word for the IDT clock synthesizer.
// Requesters use idt_pack() to build a 24-bit word from its fields.
package idt_cfg_pkg;

  localparam int R_W    = 7;
  localparam int V_W    = 9;
  localparam int S_W    = 3;
  localparam int F_W    = 2;
  localparam int TTL_W  = 1;
  localparam int C_W    = 2;
  localparam int WORD_W = C_W + TTL_W + F_W + S_W + V_W + R_W;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_SHIFT_LO = 3'd1;
  localparam state_t ST_SHIFT_HI = 3'd2;
  localparam state_t ST_STROBE   = 3'd3;
  localparam state_t ST_SETTLE   = 3'd4;

  // C=00 TTL=1 F=10 S=001 V=41 R=31: 100 MHz reference to 148.5 MHz CLK1
  localparam logic [WORD_W-1:0] IDT_INIT_WORD = 24'h31149F;

  function automatic logic [WORD_W-1:0] idt_pack(
    input logic [C_W-1:0]   c,
    input logic [TTL_W-1:0] ttl,
    input logic [F_W-1:0]   f,
    input logic [S_W-1:0]   s,
    input logic [V_W-1:0]   v,
    input logic [R_W-1:0]   r
  );
    return {c, ttl, f, s, v, r};
  endfunction

endpackage

// File: rtl/idt_cfg_ctrl.sv
// Shifts 24-bit config words MSB-first into the IDT synthesizer, strobes, then waits for PLL settle.
// Latency 1+48*CLK_DIV+STROBE_CYCLES+SETTLE_CYCLES cycles per word; cfg_ready is low for the whole sequence.
module idt_cfg_ctrl
  import idt_cfg_pkg::*;
#(
  parameter int                 CLK_DIV       = 4,
  parameter int                 STROBE_CYCLES = 4,
  parameter int                 SETTLE_CYCLES = 20000,
  parameter bit                 INIT_EN       = 1'b1,
  parameter logic [WORD_W-1:0]  INIT_WORD     = IDT_INIT_WORD
) (
  input  logic              osc_clk,
  input  logic              osc_reset_,
  input  logic              cfg_valid,
  input  logic [WORD_W-1:0] cfg_word,
  output logic              cfg_ready,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic              cfg_locked,
  output logic              idt_sclk,
  output logic              idt_data,
  output logic              idt_strobe
);

  localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
  localparam logic [15:0] STROBE_LAST = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  state_t            state;
  logic              init_pending;
  logic              run_q;
  logic [WORD_W-1:0] shift_q;
  logic [4:0]        bit_idx;
  logic [15:0]       cnt;
  logic              accept;

  // run_q keeps cfg_ready low while reset is held, even with INIT_EN=0
  assign cfg_ready = run_q && (state == ST_IDLE) && !init_pending;
  assign accept    = cfg_valid && cfg_ready;

  always_ff @(posedge osc_clk) begin
    if (!osc_reset_) begin
      state        <= ST_IDLE;
      init_pending <= INIT_EN;
      run_q        <= 1'b0;
      shift_q      <= '0;
      bit_idx      <= '0;
      cnt          <= '0;
      cfg_busy     <= 1'b0;
      cfg_done     <= 1'b0;
      cfg_locked   <= 1'b0;
      idt_sclk     <= 1'b0;
      idt_data     <= 1'b0;
      idt_strobe   <= 1'b0;
    end else begin
      run_q    <= 1'b1;
      cfg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (init_pending || accept) begin
            shift_q      <= init_pending ? INIT_WORD : cfg_word;
            idt_data     <= init_pending ? INIT_WORD[WORD_W-1] : cfg_word[WORD_W-1];
            init_pending <= 1'b0;
            bit_idx      <= 5'(WORD_W - 1);
            cnt          <= '0;
            cfg_busy     <= 1'b1;
            cfg_locked   <= 1'b0;
            idt_sclk     <= 1'b0;
            state        <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            idt_sclk <= 1'b1;
            state    <= ST_SHIFT_HI;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SHIFT_HI: begin
          if (cnt == DIV_LAST) begin
            cnt      <= '0;
            idt_sclk <= 1'b0;
            if (bit_idx == 5'd0) begin
              idt_data   <= 1'b0;
              idt_strobe <= 1'b1;
              state      <= ST_STROBE;
            end else begin
              // data moves only on the falling sclk edge, a full phase after the rise
              bit_idx  <= bit_idx - 5'd1;
              shift_q  <= {shift_q[WORD_W-2:0], 1'b0};
              idt_data <= shift_q[WORD_W-2];
              state    <= ST_SHIFT_LO;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_STROBE: begin
          if (cnt == STROBE_LAST) begin
            cnt        <= '0;
            idt_strobe <= 1'b0;
            state      <= ST_SETTLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt        <= '0;
            cfg_done   <= 1'b1;
            cfg_busy   <= 1'b0;
            cfg_locked <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idt_cfg_ctrl.sv
// Bench for idt_cfg_ctrl: four instances with different timing parameters share one monitor
// that derives the expected serial waveform from the cycle-numbering rules.
module tb_idt_cfg_ctrl;
  import idt_cfg_pkg::*;

  localparam logic [23:0] MID_INIT = 24'h5C3A81;

  logic osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  logic [3:0]  rst_n;
  logic [3:0]  vld;
  logic [23:0] wrd [4];
  wire  [3:0]  rdy, busy, done, lock, sclk, sdat, stb;

  int divs[4]    = '{4, 1, 3, 8};
  int stbs[4]    = '{4, 2, 3, 1};
  int settles[4] = '{20000, 10, 12, 5};

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] sel;
  logic m_rdy, m_busy, m_done, m_lock, m_sclk, m_data, m_stb;

  always_comb begin
    m_rdy  = rdy[sel];
    m_busy = busy[sel];
    m_done = done[sel];
    m_lock = lock[sel];
    m_sclk = sclk[sel];
    m_data = sdat[sel];
    m_stb  = stb[sel];
  end

  idt_cfg_ctrl u_main (
    .osc_clk(osc_clk), .osc_reset_(rst_n[0]), .cfg_valid(vld[0]), .cfg_word(wrd[0]),
    .cfg_ready(rdy[0]), .cfg_busy(busy[0]), .cfg_done(done[0]), .cfg_locked(lock[0]),
    .idt_sclk(sclk[0]), .idt_data(sdat[0]), .idt_strobe(stb[0])
  );

  idt_cfg_ctrl #(.CLK_DIV(1), .STROBE_CYCLES(2), .SETTLE_CYCLES(10), .INIT_EN(1'b0)) u_fast (
    .osc_clk(osc_clk), .osc_reset_(rst_n[1]), .cfg_valid(vld[1]), .cfg_word(wrd[1]),
    .cfg_ready(rdy[1]), .cfg_busy(busy[1]), .cfg_done(done[1]), .cfg_locked(lock[1]),
    .idt_sclk(sclk[1]), .idt_data(sdat[1]), .idt_strobe(stb[1])
  );

  idt_cfg_ctrl #(.CLK_DIV(3), .STROBE_CYCLES(3), .SETTLE_CYCLES(12), .INIT_EN(1'b1),
                 .INIT_WORD(MID_INIT)) u_mid (
    .osc_clk(osc_clk), .osc_reset_(rst_n[2]), .cfg_valid(vld[2]), .cfg_word(wrd[2]),
    .cfg_ready(rdy[2]), .cfg_busy(busy[2]), .cfg_done(done[2]), .cfg_locked(lock[2]),
    .idt_sclk(sclk[2]), .idt_data(sdat[2]), .idt_strobe(stb[2])
  );

  idt_cfg_ctrl #(.CLK_DIV(8), .STROBE_CYCLES(1), .SETTLE_CYCLES(5), .INIT_EN(1'b0)) u_slow (
    .osc_clk(osc_clk), .osc_reset_(rst_n[3]), .cfg_valid(vld[3]), .cfg_word(wrd[3]),
    .cfg_ready(rdy[3]), .cfg_busy(busy[3]), .cfg_done(done[3]), .cfg_locked(lock[3]),
    .idt_sclk(sclk[3]), .idt_data(sdat[3]), .idt_strobe(stb[3])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Called just after the accept/init edge (cycle 0); returns at the negedge of the cfg_done cycle.
  task automatic observe(input int div, input int stb_n, input int settle_n,
                         input logic [23:0] exp_word, input string tag);
    logic [23:0] bits;
    int nrise, rise_bad, unstable, overlap, stb_cnt, stb_first, stb_last;
    int done_cyc, rdy_bad, lock_bad, busy_bad, last_chg, last_rise, budget;
    logic prev_sclk, prev_data;
    bits = '0; nrise = 0; rise_bad = 0; unstable = 0; overlap = 0; stb_cnt = 0;
    stb_first = -1; stb_last = -1; done_cyc = -1; rdy_bad = 0; lock_bad = 0; busy_bad = 0;
    last_chg = -1000; last_rise = -1000; prev_sclk = 1'b0; prev_data = 1'b0;
    budget = 48 * div + stb_n + settle_n + 20;
    for (int t = 1; t <= budget; t++) begin
      @(negedge osc_clk);
      if (m_done) begin
        done_cyc = t;
        break;
      end
      if (m_rdy)   rdy_bad++;
      if (m_lock)  lock_bad++;
      if (!m_busy) busy_bad++;
      if (m_stb) begin
        stb_cnt++;
        if (stb_first < 0) stb_first = t;
        stb_last = t;
        if (m_sclk) overlap++;
      end
      if (m_data !== prev_data) begin
        if (m_sclk) unstable++;
        if (t - last_rise < div) unstable++;
        last_chg = t;
      end
      if (m_sclk && !prev_sclk) begin
        if (t - last_chg < div) unstable++;
        if (t != 1 + (2 * nrise + 1) * div) rise_bad++;
        bits = {bits[22:0], m_data};
        nrise++;
        last_rise = t;
      end
      prev_sclk = m_sclk;
      prev_data = m_data;
    end
    check_eq({tag, "_bits"},      bits,      exp_word);
    check_eq({tag, "_nrise"},     nrise,     24);
    check_eq({tag, "_rise_time"}, rise_bad,  0);
    check_eq({tag, "_stable"},    unstable,  0);
    check_eq({tag, "_overlap"},   overlap,   0);
    check_eq({tag, "_stb_first"}, stb_first, 48 * div + 1);
    check_eq({tag, "_stb_last"},  stb_last,  48 * div + stb_n);
    check_eq({tag, "_stb_cnt"},   stb_cnt,   stb_n);
    check_eq({tag, "_done_cyc"},  done_cyc,  1 + 48 * div + stb_n + settle_n);
    check_eq({tag, "_rdy_low"},   rdy_bad,   0);
    check_eq({tag, "_lock_low"},  lock_bad,  0);
    check_eq({tag, "_busy_hi"},   busy_bad,  0);
    // {locked, busy, ready, sclk, data, strobe} on the done cycle
    check_eq({tag, "_end_state"}, {m_lock, m_busy, m_rdy, m_sclk, m_data, m_stb}, 6'b101000);
  endtask

  initial begin
    int d, gap;
    logic [23:0] w;
    rst_n = '0;
    vld   = '0;
    for (int i = 0; i < 4; i++) wrd[i] = '0;
    sel = 2'd0;

    repeat (3) @(negedge osc_clk);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("reset_outs%0d", i),
               {rdy[i], busy[i], done[i], lock[i], sclk[i], sdat[i], stb[i]}, 7'd0);

    // First osc_reset_=1 edge is cycle 0 of the init load
    rst_n = 4'hF;
    @(posedge osc_clk);
    observe(4, 4, 20000, 24'h31149F, "init");

    // Back-to-back: second word held on cfg_valid during the first sequence
    sel = 2'd1;
    vld[1] = 1'b1;
    wrd[1] = 24'hA5A5A5;
    #1 check_eq("a5_rdy", m_rdy, 1);
    @(posedge osc_clk);
    #1 wrd[1] = 24'h000001;
    observe(1, 2, 10, 24'hA5A5A5, "a5");
    @(posedge osc_clk);
    #1 vld[1] = 1'b0;
    wrd[1] = 24'hFFFFFF;
    observe(1, 2, 10, 24'h000001, "b2b");

    // Reset at cycle 100 of a sequence aborts it; init word reruns afterwards
    @(negedge osc_clk);
    sel = 2'd2;
    vld[2] = 1'b1;
    wrd[2] = 24'h123456;
    #1 check_eq("mid_rdy", m_rdy, 1);
    @(posedge osc_clk);
    #1 vld[2] = 1'b0;
    repeat (100) @(negedge osc_clk);
    rst_n[2] = 1'b0;
    @(negedge osc_clk);
    check_eq("abort_outs", {m_rdy, m_busy, m_done, m_lock, m_sclk, m_data, m_stb}, 7'd0);
    rst_n[2] = 1'b1;
    @(posedge osc_clk);
    observe(3, 3, 12, MID_INIT, "rst_init");

    for (int n = 0; n < 50; n++) begin
      d   = $urandom_range(1, 3);
      gap = $urandom_range(0, 2);
      w   = 24'($urandom);
      repeat (gap) @(negedge osc_clk);
      sel = 2'(d);
      vld[d] = 1'b1;
      wrd[d] = w;
      #1 check_eq("rnd_rdy", m_rdy, 1);
      @(posedge osc_clk);
      #1 vld[d] = 1'b0;
      wrd[d] = 24'($urandom);
      observe(divs[d], stbs[d], settles[d], w, $sformatf("rnd%0d", n));
    end

    @(negedge osc_clk);
    check_eq("final_done_clear", m_done, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/idt_cfg_ctrl.md
# idt_cfg_ctrl

Sequencer that programs the board's IDT serial-configured clock synthesizer (24-bit word: C, TTL, F, S, V, R). After reset it loads a default word automatically. Afterwards it accepts new words from a valid/ready requester, such as a video-mode switcher, and shifts each one out MSB-first, strobes it, and waits for PLL settle. It sits in the osc_clk domain and drives idt_sclk, idt_data and idt_strobe in place of the free-running counter used during bring-up.

## Interface
- CLK_DIV, 4: osc_clk cycles per sclk phase; sclk period = 2*CLK_DIV; ≥1
- STROBE_CYCLES, 4: strobe high width in cycles; ≥1
- SETTLE_CYCLES, 20000: post-strobe PLL settle wait; 1..65535
- INIT_EN, 1: program INIT_WORD automatically after reset
- INIT_WORD, 24'h31149F: C=00, TTL=1, F=10, S=001, V=41, R=31 (100 MHz in → 148.5 MHz CLK1)
- osc_clk  in  1  single clock for the block
- osc_reset_  in  1  synchronous, active-low reset
- cfg_valid  in  1  requester has a word
- cfg_word  in  24  config word {c[1:0], ttl, f[1:0], s[2:0], v[8:0], r[6:0]}
- cfg_ready  out  1  word accepted on the cycle where cfg_valid&&cfg_ready
- cfg_busy  out  1  sequence in progress
- cfg_done  out  1  one-cycle pulse at sequence end
- cfg_locked  out  1  synthesizer holds a valid programmed word and has settled
- idt_sclk  out  1  serial clock
- idt_data  out  1  serial data
- idt_strobe  out  1  load strobe

## Operation
- FSM states: IDLE, SHIFT_LO, SHIFT_HI, STROBE, SETTLE. Counters: bit index 0..23, shared 16-bit phase/wait counter.
- While osc_reset_=0, every output is 0 and state is IDLE.
- init_pending is set by reset when INIT_EN=1. The first cycle in IDLE with init_pending set loads INIT_WORD, exactly as an accepted request would, and clears init_pending.
- cfg_ready = (state==IDLE) && !init_pending. A word is captured into the shift register only on cfg_valid&&cfg_ready. cfg_word may change freely once the word is captured.
- On accept (or init load):
  - cfg_busy=1 and cfg_locked=0, because the synthesizer output is invalid during reprogramming.
  - State goes to SHIFT_LO.
- Bit shifting:
  - SHIFT_LO: sclk=0 and idt_data = current bit. Bit 23 goes first.
  - After CLK_DIV cycles, go to SHIFT_HI: sclk=1 and data held stable.
  - After CLK_DIV cycles, advance the bit. After bit 0 go to STROBE; otherwise return to SHIFT_LO.
- STROBE: sclk=0, data=0, strobe=1 for STROBE_CYCLES cycles, then go to SETTLE.
- SETTLE: all serial outputs 0 for SETTLE_CYCLES cycles. Then return to IDLE with cfg_done=1 for one cycle, cfg_locked=1 and cfg_busy=0.
- cfg_valid held during a sequence is ignored until IDLE. A word is never dropped or partially shifted.
- If reset asserts mid-sequence, the block aborts immediately: outputs go to 0, including a strobe in progress. When INIT_EN=1, the full INIT_WORD sequence reruns after reset.
- Back-to-back requests: the cycle after cfg_done, the block is already in IDLE with cfg_ready=1. A new accept clears cfg_locked again.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs, except that cfg_ready depends only on state.
- Cycle numbering: accept/init-load edge = cycle 0.
  - idt_data shows bit 23 from cycle 1.
  - The k-th sclk rise (k = 0..23) occurs at cycle 1 + (2k+1)*CLK_DIV.
  - Strobe is high during cycles 1 + 48*CLK_DIV to 48*CLK_DIV + STROBE_CYCLES.
  - cfg_done occurs at cycle 1 + 48*CLK_DIV + STROBE_CYCLES + SETTLE_CYCLES.
- With defaults: strobe high during cycles 193..196; cfg_done at cycle 20197.
- After reset release with INIT_EN=1, the first cycle with osc_reset_=1 is cycle 0.
- idt_data changes only while sclk=0. It is stable for at least CLK_DIV cycles on each side of every sclk rise.

## Structure
- Shared package idt_cfg_pkg holds:
  - field widths (R=7, V=9, S=3, F=2, TTL=1, C=2; WORD=24);
  - the FSM state enum;
  - the INIT_WORD default;
  - a pack function (c, ttl, f, s, v, r) → 24-bit word for requesters.
- No sub-module; a flat FSM plus counters.

## Test plan
- Reset release, INIT_EN=1, defaults → the 24 sampled bits on sclk rises equal 0x31149F MSB-first; strobe high during cycles 193..196; cfg_done pulse at cycle 20197; cfg_locked=1 afterwards.
- Request 24'hA5A5A5 from IDLE with CLK_DIV=1 → sclk period is 2 cycles; captured bits = A5A5A5; cfg_ready=0 from cycle 1 until cfg_done.
- cfg_valid held high with a second word (24'h000001) during a sequence → the second word is accepted only on the cycle after cfg_done; cfg_locked drops on that acceptance.
- Reset asserted at cycle 100 of a sequence → all outputs are 0 the next cycle; the init sequence restarts and completes with correct bits.
- Random CLK_DIV in 1..8 and 50 random words → every bit stable ±CLK_DIV around its sclk rise; strobe never overlaps sclk=1; cfg_done pulses exactly once per accept.
